// File: rtl/aes_sbox_rand_gen.sv
// Fresh-randomness source for the masked DOM AES S-box.
// A bank of seeded xorshift32 lanes produces one new mask set per enabled
// cycle. The lanes are sequenced through seed load, warm-up and run phases,
// and the mask buses stay zero until the lanes are seeded and warmed up.

// One xorshift32 lane: loads a seed word, or steps when asked.
module aesRandLane (
   input  logic        ClkxCI,
   input  logic        RstxBI,
   input  logic        LoadxSI,
   input  logic [31:0] LoadValxDI,
   input  logic        StepxSI,
   output logic [31:0] LanexDO
);
   logic [31:0] s1, s2, nextLane;

   // single-cycle xorshift32 update: x^=x<<13; x^=x>>17; x^=x<<5
   always_comb begin
      s1       = LanexDO ^ (LanexDO << 13);
      s2       = s1 ^ (s1 >> 17);
      nextLane = s2 ^ (s2 << 5);
   end

   // lane register; a seed load never coincides with a step, load wins anyway
   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI)      LanexDO <= '0;
      else if (LoadxSI) LanexDO <= LoadValxDI;
      else if (StepxSI) LanexDO <= nextLane;
   end
endmodule

module aes_sbox_rand_gen #(
   parameter int SHARES = 2,
   parameter int WARMUP = 16
) (
   input  logic                             ClkxCI,
   input  logic                             RstxBI,
   input  logic [31:0]                      SeedxDI,
   input  logic                             SeedValidxSI,
   output logic                             SeedReadyxSO,
   input  logic                             ReseedxSI,
   input  logic                             EnxSI,
   output logic                             RandValidxSO,
   output logic [2*SHARES*(SHARES-1)-1:0]   _Zmul1xDO,
   output logic [2*SHARES*(SHARES-1)-1:0]   _Zmul2xDO,
   output logic [2*SHARES*(SHARES-1)-1:0]   _Zmul3xDO,
   output logic [SHARES*(SHARES-1)-1:0]     _Zinv1xDO,
   output logic [SHARES*(SHARES-1)-1:0]     _Zinv2xDO,
   output logic [SHARES*(SHARES-1)-1:0]     _Zinv3xDO,
   output logic [4*SHARES-1:0]              _Bmul1xDO,
   output logic [2*SHARES-1:0]              _Binv1xDO,
   output logic [2*SHARES-1:0]              _Binv2xDO,
   output logic [2*SHARES-1:0]              _Binv3xDO
);
   localparam int R      = 9*SHARES*(SHARES-1) + 10*SHARES;
   localparam int K      = (R + 31) / 32;
   localparam int CNT_W  = $clog2(K + 1);
   localparam int WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

   localparam int ZMW = 2*SHARES*(SHARES-1);
   localparam int ZIW = SHARES*(SHARES-1);
   localparam int BMW = 4*SHARES;
   localparam int BIW = 2*SHARES;

   // bus offsets in the random word, LSB upward
   localparam int O_ZM1 = 0;
   localparam int O_ZM2 = O_ZM1 + ZMW;
   localparam int O_ZM3 = O_ZM2 + ZMW;
   localparam int O_ZI1 = O_ZM3 + ZMW;
   localparam int O_ZI2 = O_ZI1 + ZIW;
   localparam int O_ZI3 = O_ZI2 + ZIW;
   localparam int O_BM1 = O_ZI3 + ZIW;
   localparam int O_BI1 = O_BM1 + BMW;
   localparam int O_BI2 = O_BI1 + BIW;
   localparam int O_BI3 = O_BI2 + BIW;

   // an all-zero lane would stick at zero forever
   localparam logic [31:0] ZERO_SUB = 32'h2545F491;

   typedef enum logic [1:0] {SEED, WARM, RUN} stateT;

   stateT               stateQ, stateD;
   logic [CNT_W-1:0]    cntQ;
   logic [WCNT_W-1:0]   wcntQ;
   logic                accept, lastSeed, lastWarm, stepEn;
   logic [31:0]         seedVal;
   logic [K-1:0]        loadEn;
   logic [K-1:0][31:0]  lanes;
   logic [32*K-1:0]     laneFlat;
   logic [R-1:0]        masked;

   assign accept   = SeedValidxSI && (stateQ == SEED);
   assign lastSeed = (cntQ == CNT_W'(K - 1));
   assign lastWarm = (wcntQ == WCNT_W'(WARMUP - 1));
   assign seedVal  = (SeedxDI == 32'h0) ? ZERO_SUB : SeedxDI;

   // state register
   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) stateQ <= SEED;
      else         stateQ <= stateD;
   end

   // next state, handshake/valid outputs and lane step enable
   always_comb begin
      stateD       = stateQ;
      SeedReadyxSO = 1'b0;
      RandValidxSO = 1'b0;
      stepEn       = 1'b0;
      unique case (stateQ)
         SEED: begin
            SeedReadyxSO = 1'b1;
            if (accept && lastSeed) stateD = (WARMUP == 0) ? RUN : WARM;
         end
         WARM: begin
            stepEn = 1'b1;
            if (lastWarm) stateD = RUN;
         end
         RUN: begin
            RandValidxSO = 1'b1;
            // a reseed request takes precedence over stepping
            if (ReseedxSI) stateD = SEED;
            else           stepEn = EnxSI;
         end
         default: stateD = SEED;
      endcase
   end

   // seed-word and warm-up counters; both clear on any state change
   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         cntQ  <= '0;
         wcntQ <= '0;
      end else if (stateD != stateQ) begin
         cntQ  <= '0;
         wcntQ <= '0;
      end else begin
         if (accept)          cntQ  <= cntQ + 1'b1;
         if (stateQ == WARM)  wcntQ <= wcntQ + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < K; gi++) begin : gLane
         assign loadEn[gi] = accept && (cntQ == CNT_W'(gi));
         aesRandLane uLane (
            .ClkxCI     (ClkxCI),
            .RstxBI     (RstxBI),
            .LoadxSI    (loadEn[gi]),
            .LoadValxDI (seedVal),
            .StepxSI    (stepEn),
            .LanexDO    (lanes[gi])
         );
      end
      if (32*K > R) begin : gUnused
         logic unusedTop;
         assign unusedTop = ^laneFlat[32*K-1:R];
      end
   endgenerate

   assign laneFlat = lanes;
   assign masked   = laneFlat[R-1:0] & {R{RandValidxSO}};

   assign _Zmul1xDO = masked[O_ZM1 +: ZMW];
   assign _Zmul2xDO = masked[O_ZM2 +: ZMW];
   assign _Zmul3xDO = masked[O_ZM3 +: ZMW];
   assign _Zinv1xDO = masked[O_ZI1 +: ZIW];
   assign _Zinv2xDO = masked[O_ZI2 +: ZIW];
   assign _Zinv3xDO = masked[O_ZI3 +: ZIW];
   assign _Bmul1xDO = masked[O_BM1 +: BMW];
   assign _Binv1xDO = masked[O_BI1 +: BIW];
   assign _Binv2xDO = masked[O_BI2 +: BIW];
   assign _Binv3xDO = masked[O_BI3 +: BIW];
endmodule

// File: tb/tb_aes_sbox_rand_gen.sv
// Bench for aes_sbox_rand_gen: three instances (SHARES=2/WARMUP=1,
// SHARES=2/WARMUP=0, SHARES=3/WARMUP=16) share one stimulus stream and are
// compared every cycle against a phase-level reference model, with directed
// checks for the known vector, zero seed, enable hold, reseed, handshake
// gaps and asynchronous reset.
`timescale 1ns/1ps
module tb_aes_sbox_rand_gen;
   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [31:0] seed = '0;
   logic        seedVld = 1'b0, reseed = 1'b0, en = 1'b0;
   int          nErr = 0, nChk = 0;

   always #5 clk = ~clk;

   // instance A: SHARES=2, WARMUP=1
   logic rdyA, vldA;
   logic [3:0] zm1A, zm2A, zm3A, bi1A, bi2A, bi3A;
   logic [1:0] zi1A, zi2A, zi3A;
   logic [7:0] bm1A;
   // instance B: SHARES=2, WARMUP=0
   logic rdyB, vldB;
   logic [3:0] zm1B, zm2B, zm3B, bi1B, bi2B, bi3B;
   logic [1:0] zi1B, zi2B, zi3B;
   logic [7:0] bm1B;
   // instance C: SHARES=3, WARMUP=16
   logic rdyC, vldC;
   logic [11:0] zm1C, zm2C, zm3C, bm1C;
   logic [5:0]  zi1C, zi2C, zi3C, bi1C, bi2C, bi3C;

   aes_sbox_rand_gen #(.SHARES(2), .WARMUP(1)) u0 (
      .ClkxCI(clk), .RstxBI(rstN), .SeedxDI(seed), .SeedValidxSI(seedVld),
      .SeedReadyxSO(rdyA), .ReseedxSI(reseed), .EnxSI(en), .RandValidxSO(vldA),
      ._Zmul1xDO(zm1A), ._Zmul2xDO(zm2A), ._Zmul3xDO(zm3A),
      ._Zinv1xDO(zi1A), ._Zinv2xDO(zi2A), ._Zinv3xDO(zi3A),
      ._Bmul1xDO(bm1A), ._Binv1xDO(bi1A), ._Binv2xDO(bi2A), ._Binv3xDO(bi3A));

   aes_sbox_rand_gen #(.SHARES(2), .WARMUP(0)) u1 (
      .ClkxCI(clk), .RstxBI(rstN), .SeedxDI(seed), .SeedValidxSI(seedVld),
      .SeedReadyxSO(rdyB), .ReseedxSI(reseed), .EnxSI(en), .RandValidxSO(vldB),
      ._Zmul1xDO(zm1B), ._Zmul2xDO(zm2B), ._Zmul3xDO(zm3B),
      ._Zinv1xDO(zi1B), ._Zinv2xDO(zi2B), ._Zinv3xDO(zi3B),
      ._Bmul1xDO(bm1B), ._Binv1xDO(bi1B), ._Binv2xDO(bi2B), ._Binv3xDO(bi3B));

   aes_sbox_rand_gen #(.SHARES(3), .WARMUP(16)) u2 (
      .ClkxCI(clk), .RstxBI(rstN), .SeedxDI(seed), .SeedValidxSI(seedVld),
      .SeedReadyxSO(rdyC), .ReseedxSI(reseed), .EnxSI(en), .RandValidxSO(vldC),
      ._Zmul1xDO(zm1C), ._Zmul2xDO(zm2C), ._Zmul3xDO(zm3C),
      ._Zinv1xDO(zi1C), ._Zinv2xDO(zi2C), ._Zinv3xDO(zi3C),
      ._Bmul1xDO(bm1C), ._Binv1xDO(bi1C), ._Binv2xDO(bi2C), ._Binv3xDO(bi3C));

   // bus map, LSB upward: Zmul1..3, Zinv1..3, Bmul1, Binv1..3
   logic [95:0] flatA, flatB, flatC;
   assign flatA = 96'({bi3A, bi2A, bi1A, bm1A, zi3A, zi2A, zi1A, zm3A, zm2A, zm1A});
   assign flatB = 96'({bi3B, bi2B, bi1B, bm1B, zi3B, zi2B, zi1B, zm3B, zm2B, zm1B});
   assign flatC = 96'({bi3C, bi2C, bi1C, bm1C, zi3C, zi2C, zi1C, zm3C, zm2C, zm1C});

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      nChk++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] xs(input logic [31:0] x);
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      return x;
   endfunction

   // ---------------- reference model ----------------
   // phase: 0 = seeding, 1 = warming up, 2 = running
   int          kOf[3]  = '{2, 2, 3};
   int          wuOf[3] = '{1, 0, 16};
   int          rOf[3]  = '{38, 38, 84};
   int          mPh[3]  = '{0, 0, 0};
   int          mCnt[3] = '{0, 0, 0};
   int          mW[3]   = '{0, 0, 0};
   logic [31:0] mLane[3][3] = '{default: 32'h0};

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < 3; i++) begin
            mPh[i] = 0; mCnt[i] = 0; mW[i] = 0;
            for (int j = 0; j < 3; j++) mLane[i][j] = 32'h0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (mPh[i] == 0) begin
               if (seedVld) begin
                  mLane[i][mCnt[i]] = (seed == 32'h0) ? 32'h2545F491 : seed;
                  mCnt[i]++;
                  if (mCnt[i] == kOf[i]) begin
                     mCnt[i] = 0; mW[i] = 0;
                     mPh[i] = (wuOf[i] == 0) ? 2 : 1;
                  end
               end
            end else if (mPh[i] == 1) begin
               for (int j = 0; j < kOf[i]; j++) mLane[i][j] = xs(mLane[i][j]);
               mW[i]++;
               if (mW[i] == wuOf[i]) begin mPh[i] = 2; mW[i] = 0; end
            end else begin
               if (reseed) begin mPh[i] = 0; mCnt[i] = 0; end
               else if (en) for (int j = 0; j < kOf[i]; j++) mLane[i][j] = xs(mLane[i][j]);
            end
         end
      end
   end

   function automatic logic [95:0] expFlat(input int i);
      logic [95:0] w;
      w = {mLane[i][2], mLane[i][1], mLane[i][0]};
      for (int b = 0; b < 96; b++) if (b >= rOf[i]) w[b] = 1'b0;
      if (mPh[i] != 2) w = '0;
      return w;
   endfunction

   // continuous compare of every instance against the model
   always @(negedge clk) begin
      chk("vldA", vldA, mPh[0] == 2);
      chk("rdyA", rdyA, mPh[0] == 0);
      chk("busA", flatA, expFlat(0));
      chk("vldB", vldB, mPh[1] == 2);
      chk("rdyB", rdyB, mPh[1] == 0);
      chk("busB", flatB, expFlat(1));
      chk("vldC", vldC, mPh[2] == 2);
      chk("rdyC", rdyC, mPh[2] == 0);
      chk("busC", flatC, expFlat(2));
   end

   // ---------------- directed sequence ----------------
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic kvCheck(input string p);
      chk({p, "Zmul1"}, zm1A, 4'h1);
      chk({p, "Zmul2"}, zm2A, 4'h2);
      chk({p, "Zmul3"}, zm3A, 4'h0);
      chk({p, "Zinv1"}, zi1A, 2'b10);
      chk({p, "Zinv2"}, zi2A, 2'b00);
      chk({p, "Zinv3"}, zi3A, 2'b00);
      chk({p, "Bmul1"}, bm1A, 8'h01);
      chk({p, "Binv1"}, bi1A, 4'h0);
      chk({p, "Binv2"}, bi2A, 4'h4);
      chk({p, "Binv3"}, bi3A, 4'h8);
      chk({p, "Lane0"}, flatA[31:0], 32'h00042021);
   endtask

   initial begin
      logic [31:0] t;
      repeat (2) @(negedge clk);
      chk("rstVld", vldA, 1'b0);
      chk("rstRdy", rdyA, 1'b1);
      chk("rstBus", flatA, 96'h0);
      rstN = 1'b1;

      // known vector: seeds 1, 1
      seedVld = 1'b1; seed = 32'h1;
      cyc(); cyc();
      seedVld = 1'b0;
      chk("kvWarmVld", vldA, 1'b0);
      chk("kvWarmRdy", rdyA, 1'b0);
      chk("kvW0Bus", flatB[37:0], {6'h01, 32'h1});
      cyc();
      chk("kvVld", vldA, 1'b1);
      kvCheck("kv");

      // enable hold, then one pulse
      repeat (5) cyc();
      kvCheck("hold");
      en = 1'b1; cyc(); en = 1'b0;
      t = xs(32'h00042021);
      chk("enLane0", flatA[31:0], t);
      t = xs(t);
      t = xs(32'h00000001);
      t = xs(t);
      chk("enLane1", flatA[37:32], t[5:0]);

      // reseed together with enable: no step
      reseed = 1'b1; en = 1'b1; cyc(); reseed = 1'b0; en = 1'b0;
      chk("rsVld", vldA, 1'b0);
      chk("rsRdy", rdyA, 1'b1);
      chk("rsBus", flatA, 96'h0);
      chk("rsNoStep", u0.lanes[0], xs(32'h00042021));
      seedVld = 1'b1; seed = 32'h1;
      cyc(); cyc();
      seedVld = 1'b0;
      cyc();
      kvCheck("rs");

      // handshake gaps: 1, 0, 1 accepted; a third word is refused
      reseed = 1'b1; cyc(); reseed = 1'b0;
      seedVld = 1'b1; seed = 32'h12345678; cyc();
      seedVld = 1'b0; cyc();
      seedVld = 1'b1; seed = 32'hCAFEF00D; cyc();
      seed = 32'h0BADBEEF;
      chk("gapRdy", rdyA, 1'b0);
      cyc();
      seedVld = 1'b0;
      chk("gapVld", vldA, 1'b1);
      chk("gapLane0", flatA[31:0], xs(32'h12345678));
      t = xs(32'hCAFEF00D);
      chk("gapLane1", flatA[37:32], t[5:0]);

      // zero seed on the WARMUP=0 instance
      reseed = 1'b1; cyc(); reseed = 1'b0;
      seedVld = 1'b1; seed = 32'h0; cyc(); cyc();
      seedVld = 1'b0;
      chk("zsVld", vldB, 1'b1);
      chk("zsLane0", flatB[31:0], 32'h2545F491);
      chk("zsLane1", flatB[37:32], 6'h11);
      chk("zsNonZero", flatB != 96'h0, 1'b1);

      // asynchronous reset mid-run
      en = 1'b1; repeat (3) cyc(); en = 1'b0;
      #2 rstN = 1'b0;
      #1;
      chk("arVld", vldA, 1'b0);
      chk("arRdy", rdyA, 1'b1);
      chk("arBus", flatA, 96'h0);
      chk("arBusC", flatC, 96'h0);
      @(negedge clk);
      #2 rstN = 1'b1;
      @(negedge clk);

      // randomized run against the model
      repeat (10000) begin
         seedVld = 1'($urandom_range(0, 1));
         seed    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         reseed  = ($urandom_range(0, 47) == 0);
         en      = 1'($urandom_range(0, 1));
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", nErr, nChk);
      $finish;
   end
endmodule

// File: doc/aes_sbox_rand_gen.md
# aes_sbox_rand_gen

Fresh-randomness source for the masked DOM AES S-box. It runs a bank of seeded xorshift32 lanes and drives every `_Z*`/`_B*` mask bus of `aes_box` with new bits each enabled cycle. It sits directly upstream of `aes_box`, and its outputs connect one-to-one to the S-box mask inputs. A seed-load handshake, a warm-up phase and a reseed request sequence the block; masks are zero and invalid until seeding completes.

## Interface
- SHARES, 2, masking order + 1; bus widths match `aes_box`.
- WARMUP, 16, number of lane steps discarded after seeding (0 allowed).
- Derived: R = 9·SHARES·(SHARES−1) + 10·SHARES total random bits; K = ceil(R/32) lanes (SHARES=2: R=38, K=2).

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- SeedxDI  in  32  seed word.
- SeedValidxSI  in  1  seed word valid.
- SeedReadyxSO  out  1  block accepts a seed word.
- ReseedxSI  in  1  request reseed; sampled in RUN only.
- EnxSI  in  1  advance lanes; one fresh mask set per enabled cycle.
- RandValidxSO  out  1  mask buses hold valid randomness.
- _Zmul1xDO, _Zmul2xDO, _Zmul3xDO  out  2·SHARES·(SHARES−1) each  multiplier masks.
- _Zinv1xDO, _Zinv2xDO, _Zinv3xDO  out  SHARES·(SHARES−1) each  inverter masks.
- _Bmul1xDO  out  4·SHARES  multiplier blinding.
- _Binv1xDO, _Binv2xDO, _Binv3xDO  out  2·SHARES each  inverter blinding.

## Operation
- **Lane step (xorshift32):** x ^= x<<13; x ^= x>>17; x ^= x<<5. The step is a single-cycle combinational update per lane, and all lanes step together.
- **Random word:** W = {lane K−1, …, lane 0}, truncated to bits R−1:0.
- **Bus map, LSB upward:** Zmul1, Zmul2, Zmul3, Zinv1, Zinv2, Zinv3, Bmul1, Binv1, Binv2, Binv3. Unused top bits of lane K−1 are ignored.
- **Output gating:** all buses = W AND {R{RandValidxSO}}. Buses are all-zero whenever RandValidxSO = 0.
- **States:** SEED, WARM, RUN.
  - **SEED:** SeedReadyxSO = 1. Each accepted word (SeedValidxSI & SeedReadyxSO at a rising edge) loads lane[cnt], then cnt increments. Lane 0 loads first.
  - **Zero-seed substitution:** a seed word of 0 is replaced by 32'h2545F491, so no lane is ever all-zero.
  - **SEED exit:** after lane K−1 loads, go to WARM with wcnt = 0. If WARMUP = 0, go directly to RUN.
  - **WARM:** all lanes step every cycle regardless of EnxSI. After WARMUP steps, go to RUN.
  - **RUN:** RandValidxSO = 1. Lanes step on each cycle with EnxSI = 1 and hold otherwise.
  - **Reseed:** ReseedxSI = 1 in RUN → SEED on the next edge, with cnt = 0. Lane contents are retained until overwritten.
- ReseedxSI is ignored in SEED and WARM. EnxSI is ignored outside RUN.
- If ReseedxSI and EnxSI are both high in RUN, the reseed wins and the lanes do not step.

## Timing
- **Reset values:** state = SEED, cnt = 0, wcnt = 0, all lanes = 0, RandValidxSO = 0, SeedReadyxSO = 1, all buses = 0.
- **Reset mid-operation:** immediate return to the reset values. A partial seed is discarded.
- **Seeding latency:** K handshake cycles, then WARMUP cycles. RandValidxSO rises on the edge that completes the last warm-up step, or with the last seed word when WARMUP = 0.
- **Mask latency:** the mask set shown in cycle n is consumed by `aes_box` in cycle n. After an enabled edge, the next set appears on the following cycle, giving 0-cycle output latency from the lane registers.
- **Reseed latency:** RandValidxSO falls and SeedReadyxSO rises on the edge after ReseedxSI is sampled.
- **Backpressure:** SeedValidxSI may stay high across words. One word is accepted per cycle, at most K words. SeedReadyxSO drops on the edge that loads lane K−1.
- **Counter widths:** cnt is ceil(log2(K+1)) bits; wcnt is ceil(log2(WARMUP+1)) bits. Neither wraps: each clears on a state change.

## Test plan
- **Reset:** RstxBI low mid-RUN → all buses 0, RandValidxSO = 0 and SeedReadyxSO = 1 asynchronously, before the next edge.
- **Known vector (SHARES=2, WARMUP=1):**
  - Stimulus: seeds 1, 1. RandValidxSO goes high 1 cycle after the 2nd word.
  - Required values: lanes = 32'h00042021; Zmul1=4'h1, Zmul2=4'h2, Zmul3=4'h0, Zinv1=2'b10, Zinv2=2'b00, Zinv3=2'b00, Bmul1=8'h01, Binv1=4'h0, Binv2=4'h4, Binv3=4'h8.
- **Zero seed:** seeds 0, 0 with WARMUP=0 → lane0 = lane1 = 32'h2545F491 and the buses are non-zero in the first valid cycle.
- **Enable hold:** in RUN, EnxSI low for 5 cycles → buses constant. One EnxSI pulse → lane0 = xorshift32(previous value) on the next cycle.
- **Reseed:** ReseedxSI together with EnxSI in RUN → next cycle RandValidxSO = 0, buses 0, SeedReadyxSO = 1, and no lane step. A new seed pair then yields the values of the known-vector scenario again.
- **Handshake gaps:** SeedValidxSI toggles 1, 0, 1 → exactly 2 words are accepted. A 3rd valid word is not accepted (SeedReadyxSO = 0). Run a randomized compare against a reference model for 10k cycles, with SHARES = 2 and SHARES = 3.
